// File: rtl/stack_pkg.sv
// Shared sizing and lane-counting helpers for the multi-lane stack.
// Lane vectors handed to the helpers are limited to 32 lanes.
package stack_pkg;

    localparam int ENABLE  = 1;
    localparam int DISABLE = 0;
    localparam int LOW     = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Storage capacity: the top buffer adds POP entries in front of the array.
    function automatic int cap(input int depth, input int pop, input int buf_ext);
        return (buf_ext == ENABLE) ? depth + pop : depth;
    endfunction

    function automatic int cnt_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int lead_ones(input logic [31:0] vec, input int n);
        int  r;
        logic run;
        r   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < n && run && vec[i]) r++;
            else run = 1'b0;
        end
        return r;
    endfunction

    function automatic int popcnt(input logic [31:0] vec, input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && vec[i]) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_port_stack_if.sv
// Push/pop lane bundle of multi_port_stack; err exists only with STACK_ERR_FLAG_EN defined.
interface multi_port_stack_if #(
    parameter int DATA = 32,
    parameter int PUSH = 1,
    parameter int POP  = 1
);
    logic [PUSH-1:0]           push;
    logic [PUSH-1:0][DATA-1:0] wd;
    logic [POP-1:0]            pop;
    logic [POP-1:0][DATA-1:0]  rd;
    logic [POP-1:0]            v;
    logic                      busy;
`ifdef STACK_ERR_FLAG_EN
    logic                      err;

    modport master (output push, wd, pop, input rd, v, busy, err);
    modport slave  (input push, wd, pop, output rd, v, busy, err);
`else
    modport master (output push, wd, pop, input rd, v, busy);
    modport slave  (input push, wd, pop, output rd, v, busy);
`endif
endinterface

// File: rtl/stack_top_buf.sv
// Flop buffer holding the top min(count, POP) stack entries, slot 0 = top.
// Refills from the array read data and takes pushed lanes on the same edge.
module stack_top_buf
    import stack_pkg::*;
#(
    parameter int DATA = 32,
    parameter int PUSH = 1,
    parameter int POP  = 1,
    parameter int CW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   cnt_i,
    input  logic [CW-1:0]   base_i,
    input  logic [CW-1:0]   nc_i,
    input  logic [DATA-1:0] pk_i   [PUSH],
    input  logic [DATA-1:0] fill_i [POP],
    output logic [DATA-1:0] top_o  [POP]
);

    logic [DATA-1:0] slot_q [POP];
    logic [DATA-1:0] slot_d [POP];

    // Stack position p (0 = bottom) after the update comes from a pushed lane,
    // a surviving buffer slot, or the array below the old buffer.
    always_comb begin
        int cnt, base, nc, ac, p;
        cnt  = int'(cnt_i);
        base = int'(base_i);
        nc   = int'(nc_i);
        ac   = cnt - imin(cnt, POP);
        for (int j = 0; j < POP; j++) begin
            p         = nc - 1 - j;
            slot_d[j] = '0;
            if (p < 0) begin
                slot_d[j] = '0;
            end else if (p >= base) begin
                for (int k = 0; k < PUSH; k++) begin
                    if (k == p - base) slot_d[j] = pk_i[k];
                end
            end else if (p >= ac) begin
                for (int i = 0; i < POP; i++) begin
                    if (i == cnt - 1 - p) slot_d[j] = slot_q[i];
                end
            end else begin
                slot_d[j] = fill_i[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < POP; j++) slot_q[j] <= '0;
        end else begin
            for (int j = 0; j < POP; j++) slot_q[j] <= slot_d[j];
        end
    end

    assign top_o = slot_q;

endmodule

// File: rtl/multi_port_stack.sv
// Multi-lane LIFO: PUSH write lanes, POP read lanes, top entries on rd/v with zero read latency.
// Define STACK_ERR_FLAG_EN to add the sticky overflow/underflow flag bus.err.
module multi_port_stack
    import stack_pkg::*;
#(
    parameter int DATA    = 32,
    parameter int DEPTH   = 16,
    parameter int BUF_EXT = ENABLE,
    parameter int PUSH    = 1,
    parameter int POP     = 1
) (
    input  logic               clk,
    input  logic               reset,
    multi_port_stack_if.slave  bus
);

    localparam int CAP  = cap(DEPTH, POP, BUF_EXT);
    localparam int CW   = cnt_width(CAP);
    localparam int NBUF = (BUF_EXT == ENABLE) ? POP : 0;

    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   base_w, nc_w;
    logic [DATA-1:0] mem_q [DEPTH];
    logic [DATA-1:0] mem_d [DEPTH];
    logic [DATA-1:0] pk    [PUSH];
    logic [DATA-1:0] fill  [POP];
    logic [DATA-1:0] top_q [POP];
    logic [DATA-1:0] rd_w  [POP];
    logic [POP-1:0]  v_w;
    int cnt, npop, npush, nacc, base, nc, ac, nac, lo;

    // Pops apply first, pushes land on the reduced stack; excess lanes drop from the top lane down.
    always_comb begin
        cnt = int'(count_q);
        v_w = '0;
        for (int i = 0; i < POP; i++) v_w[i] = (cnt > i);
        npop    = lead_ones(32'(bus.pop & v_w), POP);
        base    = cnt - npop;
        npush   = popcnt(32'(bus.push), PUSH);
        nacc    = imin(npush, CAP - base);
        nc      = base + nacc;
        ac      = cnt - imin(cnt, NBUF);
        nac     = nc - imin(nc, NBUF);
        lo      = imin(ac, base);
        count_d = CW'(nc);
        base_w  = CW'(base);
        nc_w    = CW'(nc);
    end

    always_comb begin
        int kr;
        kr = 0;
        for (int k = 0; k < PUSH; k++) pk[k] = '0;
        for (int l = 0; l < PUSH; l++) begin
            if (bus.push[l]) begin
                for (int k = 0; k < PUSH; k++) begin
                    if (k == kr) pk[k] = bus.wd[l];
                end
                kr++;
            end
        end
    end

    // Array positions [lo, nac) change: pushed data above base, buffer spill below it.
    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            mem_d[p] = mem_q[p];
            if (p >= lo && p < nac) begin
                if (p >= base) begin
                    for (int k = 0; k < PUSH; k++) begin
                        if (k == p - base) mem_d[p] = pk[k];
                    end
                end else begin
                    for (int j = 0; j < POP; j++) begin
                        if (j == cnt - 1 - p) mem_d[p] = top_q[j];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < POP; j++) begin
            fill[j] = '0;
            for (int p = 0; p < DEPTH; p++) begin
                if (p == nc - 1 - j) fill[j] = mem_q[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int p = 0; p < DEPTH; p++) mem_q[p] <= '0;
        end else begin
            count_q <= count_d;
            for (int p = 0; p < DEPTH; p++) mem_q[p] <= mem_d[p];
        end
    end

    generate
        if (BUF_EXT == ENABLE) begin : g_buf
            stack_top_buf #(
                .DATA (DATA),
                .PUSH (PUSH),
                .POP  (POP),
                .CW   (CW)
            ) u_top_buf (
                .clk    (clk),
                .reset  (reset),
                .cnt_i  (count_q),
                .base_i (base_w),
                .nc_i   (nc_w),
                .pk_i   (pk),
                .fill_i (fill),
                .top_o  (top_q)
            );
            assign rd_w = top_q;
        end else begin : g_nobuf
            assign top_q = '{default: '0};
            always_comb begin
                for (int i = 0; i < POP; i++) begin
                    rd_w[i] = '0;
                    for (int p = 0; p < DEPTH; p++) begin
                        if (p == cnt - 1 - i) rd_w[i] = mem_q[p];
                    end
                end
            end
        end

        for (genvar gi = 0; gi < POP; gi++) begin : g_rd
            assign bus.rd[gi] = v_w[gi] ? rd_w[gi] : '0;
        end
    endgenerate

    assign bus.v    = v_w;
    assign bus.busy = (CAP - cnt) < PUSH;

`ifdef STACK_ERR_FLAG_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((nacc < npush) || ((bus.pop & ~v_w) != '0)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_multi_port_stack.sv
// Directed bench: default stack (PUSH=POP=1, buffered) and a 2-lane unbuffered DEPTH=4 stack.
module tb_multi_port_stack;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multi_port_stack_if #(.DATA(32), .PUSH(1), .POP(1)) if0 ();
    multi_port_stack_if #(.DATA(32), .PUSH(2), .POP(2)) if1 ();

    multi_port_stack #(
        .DATA(32), .DEPTH(16), .BUF_EXT(1), .PUSH(1), .POP(1)
    ) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    multi_port_stack #(
        .DATA(32), .DEPTH(4), .BUF_EXT(0), .PUSH(2), .POP(2)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        $display("cyc t=%0t rst=%b u0 push=%b pop=%b wd=%h | u1 push=%b pop=%b wd=%h",
                 $time, reset, if0.push, if0.pop, if0.wd, if1.push, if1.pop, if1.wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.push = '0;
        if0.pop  = '0;
        if1.push = '0;
        if1.pop  = '0;
    endtask

    initial begin
        if0.wd = '0;
        if1.wd = '0;
        idle();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        chk("rst_v0", if0.v, 1'b0);
        chk("rst_rd0", if0.rd, 32'h0);
        chk("rst_busy0", if0.busy, 1'b0);
        chk("rst_v1", if1.v, 2'b00);
        chk("rst_rd1", if1.rd, 64'h0);
        chk("rst_busy1", if1.busy, 1'b0);
`ifdef STACK_ERR_FLAG_EN
        chk("rst_err0", if0.err, 1'b0);
        chk("rst_err1", if1.err, 1'b0);
`endif

        // single push then pop
        if0.push = 1'b1; if0.wd = 32'hDEADBEEF;
        cyc(); idle();
        chk("push1_v", if0.v, 1'b1);
        chk("push1_rd", if0.rd, 32'hDEADBEEF);
        if0.pop = 1'b1;
        cyc(); idle();
        chk("pop1_v", if0.v, 1'b0);
        chk("pop1_rd", if0.rd, 32'h0);

        // fill to capacity 17
        for (int i = 1; i <= 17; i++) begin
            if0.push = 1'b1; if0.wd = 32'(i);
            cyc();
            chk("fill_rd", if0.rd, 32'(i));
            chk("fill_busy", if0.busy, (i == 17));
        end
        idle();

        // overflow push is dropped
        if0.push = 1'b1; if0.wd = 32'h12;
        cyc(); idle();
        chk("ovf_rd", if0.rd, 32'h11);
        chk("ovf_busy", if0.busy, 1'b1);
`ifdef STACK_ERR_FLAG_EN
        chk("ovf_err", if0.err, 1'b1);
`endif

        // drain 17 entries
        for (int k = 17; k >= 1; k--) begin
            chk("drain_rd", if0.rd, 32'(k));
            chk("drain_v", if0.v, 1'b1);
            if0.pop = 1'b1;
            cyc(); idle();
        end
        chk("drain_v_end", if0.v, 1'b0);
        chk("drain_rd_end", if0.rd, 32'h0);
        chk("drain_busy_end", if0.busy, 1'b0);

        // push+pop same cycle replaces the top
        if0.push = 1'b1; if0.wd = 32'hA;
        cyc();
        if0.push = 1'b1; if0.wd = 32'hB; if0.pop = 1'b1;
        cyc(); idle();
        chk("swap_rd", if0.rd, 32'hB);
        chk("swap_v", if0.v, 1'b1);
        if0.pop = 1'b1;
        cyc(); idle();
        chk("swap_empty_v", if0.v, 1'b0);

        // 2-lane unbuffered stack
        if1.push = 2'b11; if1.wd[0] = 32'h20; if1.wd[1] = 32'h21;
        cyc(); idle();
        chk("l2_rd0", if1.rd[0], 32'h21);
        chk("l2_rd1", if1.rd[1], 32'h20);
        chk("l2_v", if1.v, 2'b11);
        chk("l2_busy", if1.busy, 1'b0);
        if1.pop = 2'b11;
        cyc(); idle();
        chk("l2_pop_v", if1.v, 2'b00);
        chk("l2_pop_rd", if1.rd, 64'h0);

        if1.push = 2'b11; if1.wd[0] = 32'h30; if1.wd[1] = 32'h31;
        cyc(); idle();
        chk("l2_c2_busy", if1.busy, 1'b0);
        if1.push = 2'b01; if1.wd[0] = 32'h32;
        cyc(); idle();
        chk("l2_c3_busy", if1.busy, 1'b1);
        chk("l2_c3_rd0", if1.rd[0], 32'h32);
        chk("l2_c3_rd1", if1.rd[1], 32'h31);

        // only lane 0 fits; lane 1 dropped
        if1.push = 2'b11; if1.wd[0] = 32'h40; if1.wd[1] = 32'h41;
        cyc(); idle();
        chk("l2_ovf_rd0", if1.rd[0], 32'h40);
        chk("l2_ovf_rd1", if1.rd[1], 32'h32);
        chk("l2_ovf_busy", if1.busy, 1'b1);
`ifdef STACK_ERR_FLAG_EN
        chk("l2_ovf_err", if1.err, 1'b1);
`endif

        // pop on lane 1 only is ignored
        if1.pop = 2'b10;
        cyc(); idle();
        chk("l2_gap_rd0", if1.rd[0], 32'h40);

        // pop lane 0 + push lane 1
        if1.pop = 2'b01; if1.push = 2'b10; if1.wd[1] = 32'h50;
        cyc(); idle();
        chk("l2_mix_rd0", if1.rd[0], 32'h50);
        chk("l2_mix_rd1", if1.rd[1], 32'h32);

        if1.pop = 2'b11;
        cyc(); idle();
        chk("l2_pp_rd0", if1.rd[0], 32'h31);
        chk("l2_pp_rd1", if1.rd[1], 32'h30);
        chk("l2_pp_v", if1.v, 2'b11);
        chk("l2_pp_busy", if1.busy, 1'b0);
        if1.pop = 2'b11;
        cyc(); idle();
        if1.pop = 2'b11;
        cyc(); idle();
        chk("l2_empty_v", if1.v, 2'b00);

        // asynchronous reset with 5 entries stored
        for (int i = 1; i <= 5; i++) begin
            if0.push = 1'b1; if0.wd = 32'h60 + 32'(i);
            cyc();
        end
        idle();
        chk("pre_rst_rd", if0.rd, 32'h65);
        chk("pre_rst_v", if0.v, 1'b1);
        reset = 1'b1;
        if0.push = 1'b1; if0.wd = 32'h77;
        #2;
        chk("arst_v", if0.v, 1'b0);
        chk("arst_rd", if0.rd, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
        idle();
        cyc();
        chk("post_rst_v", if0.v, 1'b0);
        chk("post_rst_busy", if0.busy, 1'b0);

`ifdef STACK_ERR_FLAG_EN
        chk("post_rst_err", if0.err, 1'b0);
        if0.pop = 1'b1;
        cyc(); idle();
        chk("udf_err", if0.err, 1'b1);
        cyc();
        chk("udf_err_sticky", if0.err, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_port_stack.md
Name: multi_port_stack

Overview:
- Parameterised LIFO with PUSH write lanes and POP read lanes per cycle.
- Top entries are always presented on rd/v with zero-cycle read latency.
- Used as a generic return-address or free-list stack; busy gives producers back-pressure.

Parameters:
- DATA, 32, entry width in bits.
- DEPTH, 16, storage-array entries.
- BUF_EXT, ENABLE (1), when 1: top POP entries live in a flop buffer in front of the array; capacity CAP = DEPTH+POP. When 0: CAP = DEPTH and rd is read directly from the array.
- PUSH, 1, push lanes (>=1).
- POP, 1, pop lanes (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  PUSH  per-lane push request.
- wd  input  PUSH x DATA  per-lane push data (packed [PUSH-1:0][DATA-1:0]).
- pop  input  POP  per-lane pop request.
- rd  output  POP x DATA  rd[i] = i-th entry from top (rd[0] = top).
- v  output  POP  v[i] = 1 when count > i.
- busy  output  1  1 when free entries (CAP - count) < PUSH.

Behaviour:
- Internal count, width $clog2(CAP+1). Reset clears count to 0; all storage and buffer flops cleared to 0.
- Reset outputs: v = 0, rd = 0, busy = 0.
- Outputs are combinational from registered state. rd[i] is forced to 0 when v[i] = 0.
- Pop:
  - Effective pops = pop & v. Only contiguous lanes from lane 0 count.
  - npop = number of leading ones of (pop & v) starting at lane 0; higher lanes are ignored.
  - Popping an empty stack has no effect.
- Push:
  - npush = popcount(push).
  - Enabled lanes are pushed in ascending lane order: the lowest enabled lane goes deepest, the highest enabled lane becomes the new top.
- Same cycle: pops are applied first, then pushes on the reduced stack.
  - new_count = count - npop + npush.
  - With PUSH = POP = 1 and count >= 1, push+pop replaces the top with wd[0].
- Overflow: if count - npop + npush > CAP, lanes beyond capacity (highest lanes first) are dropped. Stored content and count saturate at CAP.
- Latency: a push at edge N is visible on rd[0]/v[0] immediately after edge N. A pop at edge N removes the entry after edge N.
- BUF_EXT = 1:
  - The buffer always holds min(count, POP) top entries.
  - Spill/fill between buffer and array happens on the same edge, with no extra latency and no bubble.
- Reset asserted mid-operation immediately empties the stack; requests in that cycle are discarded.

Optional Feature:
- Macro STACK_ERR_FLAG_EN.
- Defined: adds output err (1 bit), sticky.
  - Set on an edge where any push lane is dropped (overflow), or any pop lane is requested with v of that lane = 0 (underflow).
  - Cleared only by reset.
- Undefined: port err and its logic are absent; overflow/underflow are silently ignored as above.

Decomposition:
- Shared package stack_pkg holds:
  - capacity function cap(DEPTH, POP, BUF_EXT);
  - count-width function;
  - leading-ones and popcount helper functions.
- ENABLE/DISABLE/LOW constants come from the team's standard define header.
- One sub-module, stack_top_buf: the POP-entry top buffer with spill/fill control, instantiated only when BUF_EXT = 1.

Test Plan (DATA=32, DEPTH=16, PUSH=POP=1, BUF_EXT=1 unless noted):
- Reset 5 cycles, then release -> v = 0, rd = 0, busy = 0.
- Push 0xDEADBEEF for one cycle -> next cycle v[0] = 1, rd[0] = 0xDEADBEEF. Then pop one cycle -> v[0] = 0, rd[0] = 0.
- Push 0x1..0x11 (17 entries) -> busy = 1 after the 17th push. An 18th push (0x12) is ignored. Popping 17 times returns 0x11 down to 0x1, then v = 0.
- Push 0xA, then push 0xB with pop in the same cycle -> count stays 1, rd[0] = 0xB.
- PUSH = POP = 2, BUF_EXT = 0, DEPTH = 4:
  - push {0x20, 0x21} -> rd[0] = 0x21, rd[1] = 0x20, v = 2'b11.
  - Then pop = 2'b11 -> v = 0.
  - busy = 1 when count >= 3.
- Assert reset with 5 entries stored -> v = 0 immediately (asynchronous). With STACK_ERR_FLAG_EN defined, a pop on an empty stack sets err = 1, and it stays set until reset.
